// File: rtl/ddr2_init_sequencer_pkg.sv
// Shared definitions for the DDR2 power-up initialisation sequencer:
// command encodings, address-bit masks and the sequencer state type.
package ddr2_init_sequencer_pkg;

   // {RAS#, CAS#, WE#} with CS# low
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;

   // Mode-register address bits touched by the sequence
   localparam logic [15:0] A8_MASK   = 16'h0100;  // MR DLL reset
   localparam logic [15:0] A10_MASK  = 16'h0400;  // precharge all banks
   localparam logic [15:0] A9_7_MASK = 16'h0380;  // EMR(1) OCD calibration field

   typedef enum logic [3:0] {
      ST_WAIT_PWR,
      ST_CKE_NOP,
      ST_PRE1,
      ST_EMR2,
      ST_EMR3,
      ST_EMR1,
      ST_MR_DLLRST,
      ST_PRE2,
      ST_REF1,
      ST_REF2,
      ST_MR,
      ST_EMR_OCD_DEF,
      ST_EMR_OCD_EXIT,
      ST_DONE
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ddr2_init_sequencer_if.sv
// DDR2 command bus plus init_done, as driven by the init sequencer.
interface ddr2_init_sequencer_if #(
   parameter int ROW_WIDTH  = 13,
   parameter int BANK_WIDTH = 2
) ();
   logic                  ddr_cke;
   logic                  ddr_cs_n;
   logic                  ddr_ras_n;
   logic                  ddr_cas_n;
   logic                  ddr_we_n;
   logic [BANK_WIDTH-1:0] ddr_ba;
   logic [ROW_WIDTH-1:0]  ddr_addr;
   logic                  ddr_odt;
   logic                  init_done;

   modport master (
      output ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n,
      output ddr_ba, ddr_addr, ddr_odt, init_done
   );

   modport slave (
      input ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n,
      input ddr_ba, ddr_addr, ddr_odt, init_done
   );
endinterface

// File: rtl/ddr2_init_sequencer_timer.sv
// Loadable down-counter. A load takes priority; otherwise the count
// decrements to zero and holds there. expired_o is high at zero.
module ddr2_init_sequencer_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: load, else count down and stop at zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign expired_o = (count_q == '0);
endmodule

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up initialisation sequencer. Walks the JEDEC init sequence
// on the command bus, then deselects the device and raises init_done.
// A gap timer spaces the commands; a second timer enforces DLL lock time.
module ddr2_init_sequencer
   import ddr2_init_sequencer_pkg::*;
#(
   parameter int          ROW_WIDTH        = 13,
   parameter int          BANK_WIDTH       = 2,
   parameter int          INIT_WAIT_CYCLES = 40000,
   parameter int          CKE_NOP_CYCLES   = 80,
   parameter int          TRP_CYC          = 3,
   parameter int          TMRD_CYC         = 2,
   parameter int          TRFC_CYC         = 26,
   parameter int          DLL_LOCK_CYC     = 200,
   parameter logic [15:0] MODE_REG         = 16'h0642,
   parameter logic [15:0] EXT_MODE_REG     = 16'h0044
) (
   input  logic                clk_0,
   input  logic                sys_rst,
   ddr2_init_sequencer_if.master bus
);
   localparam int MAX_CYC = max_int(max_int(max_int(INIT_WAIT_CYCLES, CKE_NOP_CYCLES),
                                            max_int(TRP_CYC, TMRD_CYC)),
                                    max_int(TRFC_CYC, DLL_LOCK_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // A state entered on edge e with load L is left on edge e+L+1. The
   // power-up wait is loaded by the reset edge itself, one edge before cycle 0.
   localparam logic [CNT_W-1:0] L_INIT = CNT_W'(INIT_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] L_CKE  = CNT_W'(CKE_NOP_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_TRP  = CNT_W'(TRP_CYC - 1);
   localparam logic [CNT_W-1:0] L_TMRD = CNT_W'(TMRD_CYC - 1);
   localparam logic [CNT_W-1:0] L_TRFC = CNT_W'(TRFC_CYC - 1);
   localparam logic [CNT_W-1:0] L_DLL  = CNT_W'(DLL_LOCK_CYC - 1);

   localparam logic [ROW_WIDTH-1:0] ADDR_PRE    = ROW_WIDTH'(A10_MASK);
   localparam logic [ROW_WIDTH-1:0] ADDR_EMR1   = ROW_WIDTH'(EXT_MODE_REG);
   localparam logic [ROW_WIDTH-1:0] ADDR_MR_DLL = ROW_WIDTH'(MODE_REG | A8_MASK);
   localparam logic [ROW_WIDTH-1:0] ADDR_MR     = ROW_WIDTH'(MODE_REG & ~A8_MASK);
   localparam logic [ROW_WIDTH-1:0] ADDR_OCD    = ROW_WIDTH'(EXT_MODE_REG | A9_7_MASK);

   state_e                state_q, state_d;
   logic                  cke_q, cke_d;
   logic                  cs_n_q, cs_n_d;
   logic [2:0]            cmd_q, cmd_d;
   logic [BANK_WIDTH-1:0] ba_q, ba_d;
   logic [ROW_WIDTH-1:0]  addr_q, addr_d;
   logic                  odt_q, odt_d;
   logic                  init_done_q, init_done_d;

   logic                  gap_load, gap_exp, dll_load, dll_exp;
   logic [CNT_W-1:0]      gap_val;

   ddr2_init_sequencer_timer #(.W(CNT_W)) u_gap_timer (
      .clk(clk_0), .load_i(gap_load), .load_val_i(gap_val), .expired_o(gap_exp)
   );

   ddr2_init_sequencer_timer #(.W(CNT_W)) u_dll_timer (
      .clk(clk_0), .load_i(dll_load), .load_val_i(L_DLL), .expired_o(dll_exp)
   );

   // Next state, timer loads and the command issued on the entering edge
   always_comb begin
      state_d  = state_q;
      gap_load = 1'b0;
      gap_val  = '0;
      dll_load = 1'b0;
      cmd_d    = CMD_NOP;
      ba_d     = '0;
      addr_d   = '0;
      if (gap_exp) begin
         gap_load = 1'b1;
         cmd_d    = CMD_MRS;
         gap_val  = L_TMRD;
         unique case (state_q)
            ST_WAIT_PWR:     begin state_d = ST_CKE_NOP; cmd_d = CMD_NOP; gap_val = L_CKE; end
            ST_CKE_NOP:      begin state_d = ST_PRE1; cmd_d = CMD_PRE; gap_val = L_TRP; addr_d = ADDR_PRE; end
            ST_PRE1:         begin state_d = ST_EMR2; ba_d = BANK_WIDTH'(2); end
            ST_EMR2:         begin state_d = ST_EMR3; ba_d = BANK_WIDTH'(3); end
            ST_EMR3:         begin state_d = ST_EMR1; ba_d = BANK_WIDTH'(1); addr_d = ADDR_EMR1; end
            ST_EMR1:         begin state_d = ST_MR_DLLRST; addr_d = ADDR_MR_DLL; dll_load = 1'b1; end
            ST_MR_DLLRST:    begin state_d = ST_PRE2; cmd_d = CMD_PRE; gap_val = L_TRP; addr_d = ADDR_PRE; end
            ST_PRE2:         begin state_d = ST_REF1; cmd_d = CMD_REF; gap_val = L_TRFC; end
            ST_REF1:         begin state_d = ST_REF2; cmd_d = CMD_REF; gap_val = L_TRFC; end
            ST_REF2:         begin state_d = ST_MR; addr_d = ADDR_MR; end
            ST_MR:           begin state_d = ST_EMR_OCD_DEF; ba_d = BANK_WIDTH'(1); addr_d = ADDR_OCD; end
            ST_EMR_OCD_DEF:  begin state_d = ST_EMR_OCD_EXIT; ba_d = BANK_WIDTH'(1); addr_d = ADDR_EMR1; end
            // Leaving OCD exit also waits for the DLL to have locked
            ST_EMR_OCD_EXIT: begin
               cmd_d    = CMD_NOP;
               gap_load = 1'b0;
               if (dll_exp) state_d = ST_DONE;
            end
            default:         begin cmd_d = CMD_NOP; gap_load = 1'b0; end
         endcase
      end
      if (sys_rst) begin
         gap_load = 1'b1;
         gap_val  = L_INIT;
         dll_load = 1'b1;
      end
      cke_d       = (state_d != ST_WAIT_PWR);
      cs_n_d      = (state_d == ST_WAIT_PWR) || (state_d == ST_CKE_NOP) || (state_d == ST_DONE);
      odt_d       = 1'b0;
      init_done_d = (state_d == ST_DONE);
   end

   // State and registered command-bus outputs
   always_ff @(posedge clk_0) begin
      if (sys_rst) begin
         state_q     <= ST_WAIT_PWR;
         cke_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         cmd_q       <= CMD_NOP;
         ba_q        <= '0;
         addr_q      <= '0;
         odt_q       <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cke_q       <= cke_d;
         cs_n_q      <= cs_n_d;
         cmd_q       <= cmd_d;
         ba_q        <= ba_d;
         addr_q      <= addr_d;
         odt_q       <= odt_d;
         init_done_q <= init_done_d;
      end
   end

   assign bus.ddr_cke   = cke_q;
   assign bus.ddr_cs_n  = cs_n_q;
   assign bus.ddr_ras_n = cmd_q[2];
   assign bus.ddr_cas_n = cmd_q[1];
   assign bus.ddr_we_n  = cmd_q[0];
   assign bus.ddr_ba    = ba_q;
   assign bus.ddr_addr  = addr_q;
   assign bus.ddr_odt   = odt_q;
   assign bus.init_done = init_done_q;
endmodule
